door_plant: RTL and testbench

//   Behavioural garage-door/motor plant: the other end of the opener controller's interface.

---
 rtl/door_pkg.sv | 19 +
 rtl/step_timer.sv | 31 +++
 rtl/door_plant.sv | 105 ++++++++++
 tb/tb_door_plant.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared motor-state encodings for the door plant and the opener benches.
package door_pkg;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'b00,
    MS_UP    = 2'b01,
    MS_DOWN  = 2'b10,
    MS_FAULT = 2'b11
  } mstate_t;

  // Once faulted the motor stays faulted; u&d together is itself a fault.
  function automatic mstate_t next_mstate(input logic fault, input logic u, input logic d);
    if (fault || (u && d)) return MS_FAULT;
    if (u) return MS_UP;
    if (d) return MS_DOWN;
    return MS_IDLE;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Modulo-MOD counter with clear/enable; tick marks the enabled cycle that completes a period.
module step_timer #(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic r_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] base;

  // clr discards the old count but still lets this cycle count as the first of a new period
  assign base = clr ? '0 : cnt_reg;
  assign tick = en && (base == CW'(MOD - 1));

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : base + CW'(1);
    end else begin
      cnt_reg <= base;
    end
  end

endmodule

// File: rtl/door_plant.sv
// Behavioural garage-door plant: turns opener motor commands into position,
// limit switches and a sensor echo, with fault and stall detection.
module door_plant
  import door_pkg::*;
#(
  parameter int TRAVEL    = 8,
  parameter int PRESCALE  = 4,
  parameter int INIT_POS  = 0,
  parameter int STALL_LIM = 16,
  parameter int POS_W     = 4
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             u,
  input  logic             d,
  input  logic             obstruct,
  input  logic             jam,
  output logic             c,
  output logic             o,
  output logic             s,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       mstate,
  output logic             fault,
  output logic             stall
);

  localparam logic [POS_W-1:0] TOP_POS  = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0] INIT_VAL = POS_W'(INIT_POS);

  mstate_t          mstate_reg, mstate_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             c_reg, o_reg, s_reg, fault_reg, stall_reg;
  logic             driving, at_limit;
  logic             step_en, step_clr, step_tick;
  logic             stall_en, stall_tick;
  logic [1:0]       t_en, t_clr, t_tick;

  always_comb begin
    mstate_next = next_mstate(fault_reg, u, d);
    driving     = (mstate_next == MS_UP) || (mstate_next == MS_DOWN);
    at_limit    = ((mstate_next == MS_UP)   && (pos_reg == TOP_POS)) ||
                  ((mstate_next == MS_DOWN) && (pos_reg == '0));
    step_en     = driving && !jam && !at_limit;
    // A reversal restarts the partial step from scratch
    step_clr    = !step_en || (mstate_next != mstate_reg);
    stall_en    = driving && jam;
  end

  assign t_en  = {stall_en, step_en};
  assign t_clr = {!stall_en, step_clr};

  // Timer 0 paces position steps, timer 1 measures how long the motor pushes a jammed door
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_timer
      step_timer #(
        .MOD((gi == 0) ? PRESCALE : STALL_LIM)
      ) u_timer (
        .clk  (clk),
        .r_n  (r_n),
        .clr  (t_clr[gi]),
        .en   (t_en[gi]),
        .tick (t_tick[gi])
      );
    end
  endgenerate

  assign step_tick  = t_tick[0];
  assign stall_tick = t_tick[1];

  always_comb begin
    pos_next = pos_reg;
    if (step_tick) begin
      pos_next = (mstate_next == MS_UP) ? pos_reg + POS_W'(1) : pos_reg - POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      mstate_reg <= MS_IDLE;
      pos_reg    <= INIT_VAL;
      c_reg      <= (INIT_POS == 0);
      o_reg      <= (INIT_POS == TRAVEL);
      s_reg      <= 1'b0;
      fault_reg  <= 1'b0;
      stall_reg  <= 1'b0;
    end else begin
      mstate_reg <= mstate_next;
      pos_reg    <= pos_next;
      c_reg      <= (pos_next == '0);
      o_reg      <= (pos_next == TOP_POS);
      s_reg      <= obstruct;
      fault_reg  <= (mstate_next == MS_FAULT);
      stall_reg  <= stall_reg || stall_tick;
    end
  end

  assign pos    = pos_reg;
  assign mstate = mstate_reg;
  assign c      = c_reg;
  assign o      = o_reg;
  assign s      = s_reg;
  assign fault  = fault_reg;
  assign stall  = stall_reg;

endmodule

// File: tb/tb_door_plant.sv
// Bench for door_plant: directed table, hand-written corner sequences, random run vs. reference model.
module tb_door_plant;

  localparam int TRAVEL    = 8;
  localparam int PRESCALE  = 4;
  localparam int INIT_POS  = 0;
  localparam int STALL_LIM = 16;
  localparam int POS_W     = 4;

  logic             clk = 1'b0;
  logic             r_n = 1'b0;
  logic             u = 1'b0, d = 1'b0, obstruct = 1'b0, jam = 1'b0;
  logic             c, o, s, fault, stall;
  logic [POS_W-1:0] pos;
  logic [1:0]       mstate;

  door_plant #(
    .TRAVEL(TRAVEL), .PRESCALE(PRESCALE), .INIT_POS(INIT_POS),
    .STALL_LIM(STALL_LIM), .POS_W(POS_W)
  ) dut (
    .clk(clk), .r_n(r_n), .u(u), .d(d), .obstruct(obstruct), .jam(jam),
    .c(c), .o(o), .s(s), .pos(pos), .mstate(mstate), .fault(fault), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: run length of qualifying drive edges, stepping every PRESCALE of them
  int         m_pos, m_run, m_jrun;
  logic       m_fault, m_stall, m_s;
  logic [1:0] m_ms;

  task automatic model_reset();
    m_pos = INIT_POS; m_run = 0; m_jrun = 0;
    m_fault = 1'b0; m_stall = 1'b0; m_s = 1'b0; m_ms = 2'd0;
  endtask

  task automatic model_edge(input logic iu, input logic id, input logic iob, input logic ijam);
    logic [1:0] ms;
    int dir;
    logic moving;
    if (m_fault || (iu && id)) begin ms = 2'd3; m_fault = 1'b1; end
    else if (iu) ms = 2'd1;
    else if (id) ms = 2'd2;
    else ms = 2'd0;
    dir = (ms == 2'd1) ? 1 : (ms == 2'd2) ? -1 : 0;
    moving = (dir != 0) && !ijam && (m_pos + dir >= 0) && (m_pos + dir <= TRAVEL);
    if (moving) begin
      if (ms != m_ms) m_run = 0;
      m_run++;
      if (m_run % PRESCALE == 0) m_pos += dir;
    end else begin
      m_run = 0;
    end
    if ((dir != 0) && ijam) m_jrun++; else m_jrun = 0;
    if (m_jrun >= STALL_LIM) m_stall = 1'b1;
    m_s = iob;
    m_ms = ms;
  endtask

  task automatic cyc(input logic iu, input logic id, input logic iob, input logic ijam);
    u = iu; d = id; obstruct = iob; jam = ijam;
    @(posedge clk);
    #1;
    model_edge(iu, id, iob, ijam);
  endtask

  task automatic do_reset();
    @(negedge clk);
    u = 0; d = 0; obstruct = 0; jam = 0;
    r_n = 1'b0;
    @(negedge clk);
    r_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic u, d, ob, jam;
    int   n;
    int   pos;
    logic c, o, s;
    logic [1:0] ms;
    logic fault, stall;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // u d ob jam  n  pos c o s  ms fault stall
    tbl.push_back('{0, 0, 0, 0,  1, 0, 1, 0, 0, 2'd0, 0, 0});
    tbl.push_back('{1, 0, 0, 0,  3, 0, 1, 0, 0, 2'd1, 0, 0});
    tbl.push_back('{1, 0, 0, 0,  1, 1, 0, 0, 0, 2'd1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 27, 7, 0, 0, 0, 2'd1, 0, 0});
    tbl.push_back('{1, 0, 0, 0,  1, 8, 0, 1, 0, 2'd1, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 10, 8, 0, 1, 1, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 12, 5, 0, 0, 0, 2'd2, 0, 0});
    tbl.push_back('{1, 0, 0, 0,  3, 5, 0, 0, 0, 2'd1, 0, 0});
    tbl.push_back('{1, 0, 0, 0,  1, 6, 0, 0, 0, 2'd1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 12, 3, 0, 0, 0, 2'd2, 0, 0});
    tbl.push_back('{1, 1, 0, 0,  1, 3, 0, 0, 0, 2'd3, 1, 0});
    tbl.push_back('{1, 0, 0, 0,  8, 3, 0, 0, 0, 2'd3, 1, 0});
    tbl.push_back('{0, 1, 1, 0,  6, 3, 0, 0, 1, 2'd3, 1, 0});
    tbl.push_back('{0, 0, 0, 0,  2, 3, 0, 0, 0, 2'd3, 1, 0});

    // Reset state straight out of async reset
    do_reset();
    chk("rst_pos", 32'(pos), 32'(INIT_POS));
    chk("rst_c", 32'(c), 32'd1);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_ms", 32'(mstate), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].u, tbl[i].d, tbl[i].ob, tbl[i].jam);
      chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(tbl[i].pos));
      chk($sformatf("vec%0d_c", i), 32'(c), 32'(tbl[i].c));
      chk($sformatf("vec%0d_o", i), 32'(o), 32'(tbl[i].o));
      chk($sformatf("vec%0d_s", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("vec%0d_ms", i), 32'(mstate), 32'(tbl[i].ms));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(tbl[i].fault));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
      $display("vec %0d: pos=%0d c=%0b o=%0b s=%0b ms=%0d fault=%0b stall=%0b",
               i, pos, c, o, s, mstate, fault, stall);
    end

    // Jammed while driving down: pos frozen, stall after exactly STALL_LIM edges, then resumes
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0);
    chk("jam_start_pos", 32'(pos), 32'd4);
    for (int k = 0; k < 15; k++) cyc(0, 1, 0, 1);
    chk("jam15_stall", 32'(stall), 32'd0);
    chk("jam15_pos", 32'(pos), 32'd4);
    cyc(0, 1, 0, 1);
    chk("jam16_stall", 32'(stall), 32'd1);
    chk("jam16_pos", 32'(pos), 32'd4);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    chk("unjam3_pos", 32'(pos), 32'd4);
    cyc(0, 1, 0, 0);
    chk("unjam4_pos", 32'(pos), 32'd3);
    chk("stall_sticky", 32'(stall), 32'd1);
    $display("jam seq: pos=%0d stall=%0b", pos, stall);

    // Async reset mid-step at pos=5, no clock edge needed
    do_reset();
    for (int k = 0; k < 22; k++) cyc(1, 0, 0, 0);
    chk("pre_rst_pos", 32'(pos), 32'd5);
    #2;
    r_n = 1'b0;
    #1;
    chk("async_pos", 32'(pos), 32'd0);
    chk("async_c", 32'(c), 32'd1);
    chk("async_ms", 32'(mstate), 32'd0);
    @(negedge clk);
    r_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
    chk("post_rst3_pos", 32'(pos), 32'd0);
    cyc(1, 0, 0, 0);
    chk("post_rst4_pos", 32'(pos), 32'd1);
    $display("async reset seq: pos=%0d c=%0b", pos, c);

    // Random run against the reference model
    do_reset();
    begin
      logic ru, rd, rjam;
      int hold;
      ru = 0; rd = 0; rjam = 0; hold = 0;
      for (int k = 0; k < 3000; k++) begin
        logic [9:0] act, exp;
        if ($urandom_range(0, 399) == 0) do_reset();
        if (hold == 0) begin
          case ($urandom_range(0, 39))
            0:             begin ru = 1; rd = 1; end
            1, 2, 3, 4, 5: begin ru = 0; rd = 0; end
            default: begin
              ru = $urandom_range(0, 1);
              rd = !ru;
            end
          endcase
          hold = $urandom_range(1, 40);
        end
        hold--;
        if ($urandom_range(0, 19) == 0) rjam = !rjam;
        cyc(ru, rd, 1'($urandom_range(0, 1)), rjam);
        act = {pos, c, o, s, mstate, fault, stall};
        exp = {POS_W'(m_pos), (m_pos == 0), (m_pos == TRAVEL), m_s, m_ms, m_fault, m_stall};
        chk($sformatf("rand%0d", k), 32'(act), 32'(exp));
      end
      $display("random run: final pos=%0d ms=%0d fault=%0b stall=%0b", pos, mstate, fault, stall);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
